pulse_length_controller: RTL and testbench

//  Sequences the tick_generator to measure how long a push-button is held and

---
 rtl/pulse_length_controller.sv | 139 +++++++++++++
 tb/tb_pulse_length_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pulse_length_controller.sv
// Push-button press-length meter: synchronises and debounces btn_in, runs the
// external tick_generator while the button is held, and reports each press as
// a one-cycle SHORT or LONG strobe with its length in ticks.
module pulse_length_controller #(
    parameter int TICK_W       = 15,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int LONG_TH      = 5000,
    parameter int MAX_TH       = 30000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    input  logic [TICK_W-1:0] tick_total,
    output logic              tg_start,
    output logic              short_pulse,
    output logic              long_pulse,
    output logic [TICK_W-1:0] pulse_len,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TICK_W-1:0] LONG_V   = TICK_W'(LONG_TH);
    localparam logic [TICK_W-1:0] MAX_V    = TICK_W'(MAX_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_CLASSIFY,
        S_REPORT_OVF,
        S_WAIT_REL
    } state_t;

    state_t            state, state_nx;
    logic              btn_meta, btn_s;
    logic              btn_db, btn_db_q;
    logic [CNT_W-1:0]  db_cnt;
    logic [TICK_W-1:0] t_start;
    logic [TICK_W-1:0] len;
    logic              db_rise, db_fall;
    logic              ld_len, ld_ovf;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // Debounce: btn_db follows btn_s only after DEBOUNCE_CYC consecutive
    // samples that disagree with it; any return to agreement restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_cnt <= '0;
                btn_db <= btn_s;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign db_rise = btn_db & ~btn_db_q;
    assign db_fall = ~btn_db & btn_db_q;

    // Modular difference keeps the measurement correct across tick wrap
    assign len = tick_total - t_start;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; ld_len / ld_ovf mark the cycle the result is captured
    always_comb begin
        state_nx = state;
        ld_len   = 1'b0;
        ld_ovf   = 1'b0;
        case (state)
            S_IDLE:       if (db_rise) state_nx = S_ARM;
            S_ARM:        state_nx = S_MEASURE;
            S_MEASURE: begin
                // Hitting the ceiling wins over a release on the same cycle
                if (len >= MAX_V) begin
                    state_nx = S_REPORT_OVF;
                    ld_ovf   = 1'b1;
                end else if (db_fall) begin
                    state_nx = S_CLASSIFY;
                    ld_len   = 1'b1;
                end
            end
            S_CLASSIFY:   state_nx = S_IDLE;
            S_REPORT_OVF: state_nx = S_WAIT_REL;
            // Level check so a release that landed during REPORT_OVF is not lost
            S_WAIT_REL:   if (!btn_db) state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    // Start timestamp and result registers; results are loaded on entry to
    // the reporting state so they are valid alongside the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_start   <= '0;
            pulse_len <= '0;
            overflow  <= 1'b0;
        end else begin
            if (state == S_ARM) t_start <= tick_total;
            if (ld_len) begin
                pulse_len <= len;
                overflow  <= 1'b0;
            end else if (ld_ovf) begin
                pulse_len <= MAX_V;
                overflow  <= 1'b1;
            end
        end
    end

    assign tg_start    = (state == S_ARM) || (state == S_MEASURE);
    assign busy        = (state != S_IDLE);
    assign short_pulse = (state == S_CLASSIFY) && (pulse_len < LONG_V);
    assign long_pulse  = ((state == S_CLASSIFY) && (pulse_len >= LONG_V)) ||
                         (state == S_REPORT_OVF);

endmodule

// File: tb/tb_pulse_length_controller.sv
// Directed bench for pulse_length_controller with a tick_generator model and
// an event scoreboard.
module tb_pulse_length_controller;

    localparam int TICK_W = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              btn_in = 1'b0;
    logic [TICK_W-1:0] tick_total;
    logic              tg_start, short_pulse, long_pulse, overflow, busy;
    logic [TICK_W-1:0] pulse_len;

    logic              preload_en = 1'b0;
    logic [TICK_W-1:0] preload_val = '0;

    typedef struct {
        logic lng;
        int   lo;
        int   hi;
        logic ovf;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic saw_busy;

    pulse_length_controller #(
        .TICK_W(TICK_W), .DEBOUNCE_CYC(4), .LONG_TH(100), .MAX_TH(1000)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .tick_total(tick_total),
        .tg_start(tg_start), .short_pulse(short_pulse), .long_pulse(long_pulse),
        .pulse_len(pulse_len), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // tick_generator model: counts while enabled, preloadable by the bench
    always_ff @(posedge clk) begin
        if (preload_en)    tick_total <= preload_val;
        else if (tg_start) tick_total <= tick_total + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (reset && (short_pulse || long_pulse)) begin
            chk("no_overlap", 32'(short_pulse & long_pulse), 0);
            if (q.size() == 0) begin
                chk("unexpected_evt", 32'(q.size()), 1);
            end else begin
                exp_t e;
                int   want;
                e = q.pop_front();
                chk("evt_long", 32'(long_pulse), 32'(e.lng));
                want = (int'(pulse_len) >= e.lo && int'(pulse_len) <= e.hi) ? int'(pulse_len) : e.lo;
                chk("pulse_len", 32'(pulse_len), 32'(want));
                chk("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    task automatic expect_evt(input logic lng, input int lo, input int hi, input logic ovf);
        exp_t e;
        e.lng = lng; e.lo = lo; e.hi = hi; e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic hold(input int n);
        btn_in = 1'b1;
        repeat (n) @(negedge clk);
        btn_in = 1'b0;
    endtask

    task automatic settle(input string tag);
        repeat (20) @(negedge clk);
        chk({tag, "_drained"}, 32'(q.size()), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tg_start"}, 32'(tg_start), 0);
    endtask

    initial begin
        // 1: reset with the button held
        preload_en  = 1'b1;
        preload_val = '0;
        btn_in      = 1'b1;
        repeat (5) @(negedge clk);
        preload_en  = 1'b0;
        chk("rst_tg_start", 32'(tg_start), 0);
        chk("rst_short", 32'(short_pulse), 0);
        chk("rst_long", 32'(long_pulse), 0);
        chk("rst_len", 32'(pulse_len), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        expect_evt(1'b0, 58, 60, 1'b0);
        reset = 1'b1;
        hold(60);
        settle("rst_press");

        // 2: short press
        expect_evt(1'b0, 49, 51, 1'b0);
        hold(50);
        settle("short");

        // 3: threshold boundary
        expect_evt(1'b0, 99, 99, 1'b0);
        hold(100);
        settle("len99");
        expect_evt(1'b1, 100, 100, 1'b0);
        hold(101);
        settle("len100");

        // 4: tick counter wraps mid-press
        preload_val = 15'd32760;
        preload_en  = 1'b1;
        @(negedge clk);
        preload_en  = 1'b0;
        expect_evt(1'b0, 40, 40, 1'b0);
        hold(41);
        settle("wrap");

        // 5: overflow, no second event at release, then cleared by next press
        expect_evt(1'b1, 1000, 1000, 1'b1);
        hold(2000);
        settle("ovf");
        chk("ovf_held", 32'(overflow), 1);
        chk("ovf_len_held", 32'(pulse_len), 1000);
        expect_evt(1'b0, 29, 29, 1'b0);
        hold(30);
        settle("ovf_clear");
        chk("ovf_cleared", 32'(overflow), 0);

        // 6a: glitches shorter than the debounce window
        saw_busy = 1'b0;
        for (int g = 0; g < 3; g++) begin
            btn_in = 1'b1;
            repeat (3) begin @(negedge clk); saw_busy |= busy; end
            btn_in = 1'b0;
            repeat (6) begin @(negedge clk); saw_busy |= busy; end
        end
        chk("glitch_busy", 32'(saw_busy), 0);
        settle("glitch");

        // 6b: reset during MEASURE aborts silently
        btn_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_tg_start", 32'(tg_start), 1);
        reset = 1'b0;
        #1;
        chk("abort_tg_start", 32'(tg_start), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_short", 32'(short_pulse), 0);
        chk("abort_long", 32'(long_pulse), 0);
        @(negedge clk);
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        settle("abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
